// File: rtl/pcie_egress_tlp_builder_if.sv
// Controller descriptor, ppfifo read side and TX stream of the egress TLP builder.
// The master modport is the builder's view; slave is the controller/FIFO/TX-sink side.
interface pcie_egress_tlp_builder_if;
  logic        i_enable;
  logic        o_finished;
  logic [7:0]  i_tlp_command;
  logic [13:0] i_tlp_flags;
  logic [31:0] i_tlp_address;
  logic [15:0] i_tlp_requester_id;
  logic [7:0]  i_tlp_tag;
  logic        i_pcie_fc_ready;
  logic        i_fifo_rdy;
  logic        o_fifo_act;
  logic [23:0] i_fifo_size;
  logic        o_fifo_stb;
  logic [31:0] i_fifo_data;
  logic [31:0] o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_tx_last;
  logic        o_truncated;

  modport master (
    input  i_enable, i_tlp_command, i_tlp_flags, i_tlp_address,
    input  i_tlp_requester_id, i_tlp_tag, i_pcie_fc_ready,
    input  i_fifo_rdy, i_fifo_size, i_fifo_data, i_tx_ready,
    output o_finished, o_fifo_act, o_fifo_stb,
    output o_tx_data, o_tx_valid, o_tx_last, o_truncated
  );

  modport slave (
    output i_enable, i_tlp_command, i_tlp_flags, i_tlp_address,
    output i_tlp_requester_id, i_tlp_tag, i_pcie_fc_ready,
    output i_fifo_rdy, i_fifo_size, i_fifo_data, i_tx_ready,
    input  o_finished, o_fifo_act, o_fifo_stb,
    input  o_tx_data, o_tx_valid, o_tx_last, o_truncated
  );
endinterface

// File: rtl/pcie_egress_tlp_builder.sv
// Drains one ppfifo block into a 3DW MWr TLP on the TX stream; first header beat 3 cycles after enable.
// Each beat holds valid/data until i_tx_ready; FIFO words pop only on accepted data beats.
module pcie_egress_tlp_builder #(
  parameter int MAX_PAYLOAD_DW = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  pcie_egress_tlp_builder_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRAB, S_WAIT_FC, S_HDR0, S_HDR1, S_HDR2, S_DATA, S_FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  len_q, len_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [31:0] hdr_q, hdr_d;
  logic        act_q, act_d;
  logic        vld_q, vld_d;
  logic        last_q, last_d;
  logic        fin_q, fin_d;
  logic        trunc_q, trunc_d;
  logic        beat_acc;
  logic [7:0]  be;

  assign beat_acc = vld_q && bus.i_tx_ready;
  assign be       = (len_q == 10'd1) ? 8'h0F : 8'hFF;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    act_d   = act_q;
    vld_d   = vld_q;
    last_d  = last_q;
    fin_d   = fin_q;
    trunc_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_enable && bus.i_fifo_rdy) begin
          act_d   = 1'b1;
          state_d = S_GRAB;
        end
      end
      S_GRAB: begin
        if (bus.i_fifo_size > 24'(MAX_PAYLOAD_DW)) begin
          len_d   = 10'(MAX_PAYLOAD_DW);
          trunc_d = 1'b1;
        end else begin
          len_d = bus.i_fifo_size[9:0];
        end
        // An empty block completes the handshake without emitting a TLP.
        if (bus.i_fifo_size == 24'd0) begin
          act_d   = 1'b0;
          fin_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          state_d = S_WAIT_FC;
        end
      end
      S_WAIT_FC: begin
        if (bus.i_pcie_fc_ready) begin
          hdr_d   = {bus.i_tlp_command, bus.i_tlp_flags, len_q};
          vld_d   = 1'b1;
          state_d = S_HDR0;
        end
      end
      S_HDR0: begin
        if (beat_acc) begin
          hdr_d   = {bus.i_tlp_requester_id, bus.i_tlp_tag, be};
          state_d = S_HDR1;
        end
      end
      S_HDR1: begin
        if (beat_acc) begin
          hdr_d   = bus.i_tlp_address & 32'hFFFF_FFFC;
          state_d = S_HDR2;
        end
      end
      S_HDR2: begin
        if (beat_acc) begin
          hdr_d   = 32'h0;
          cnt_d   = len_q;
          last_d  = (len_q == 10'd1);
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (beat_acc) begin
          if (cnt_q == 10'd1) begin
            // Dropping act lets the ppfifo discard any words beyond the cap.
            vld_d   = 1'b0;
            last_d  = 1'b0;
            act_d   = 1'b0;
            fin_d   = 1'b1;
            state_d = S_FINISH;
          end else begin
            cnt_d  = cnt_q - 10'd1;
            last_d = (cnt_q == 10'd2);
          end
        end
      end
      S_FINISH: begin
        if (!bus.i_enable) begin
          fin_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= 10'd0;
      cnt_q   <= 10'd0;
      hdr_q   <= 32'h0;
      act_q   <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      fin_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      act_q   <= act_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      fin_q   <= fin_d;
      trunc_q <= trunc_d;
    end
  end

  // Payload is the FWFT head word, so it stays stable until the strobe pops it.
  assign bus.o_tx_data   = (state_q == S_DATA) ? bus.i_fifo_data : hdr_q;
  assign bus.o_tx_valid  = vld_q;
  assign bus.o_tx_last   = last_q;
  assign bus.o_fifo_act  = act_q;
  assign bus.o_fifo_stb  = (state_q == S_DATA) && beat_acc;
  assign bus.o_finished  = fin_q;
  assign bus.o_truncated = trunc_q;

endmodule

// File: tb/tb_pcie_egress_tlp_builder.sv
// Directed bench for pcie_egress_tlp_builder with a FWFT FIFO model and TX beat capture.
module tb_pcie_egress_tlp_builder;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  pcie_egress_tlp_builder_if bus();

  pcie_egress_tlp_builder #(.MAX_PAYLOAD_DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  int          rd;
  int          wr;
  logic [31:0] beats [$];
  int          last_idx, last_cnt, stb_cnt, trunc_cnt, first_vld, unstable;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dw(input int seed, input int i);
    return 32'hD000_0000 | (32'(seed) << 16) | 32'(i);
  endfunction

  task automatic upd_fifo();
    bus.i_fifo_size = 24'(wr - rd);
    bus.i_fifo_data = (rd < wr) ? mem[rd] : 32'h0;
  endtask

  task automatic load(input int n, input int seed);
    for (int i = 0; i < n; i++) mem[i] = dw(seed, i);
    rd = 0;
    wr = n;
    upd_fifo();
    bus.i_fifo_rdy = 1'b1;
  endtask

  task automatic set_desc(input logic [7:0] cmd, input logic [13:0] flags,
                          input logic [31:0] addr, input logic [15:0] rid,
                          input logic [7:0] tag);
    bus.i_tlp_command      = cmd;
    bus.i_tlp_flags        = flags;
    bus.i_tlp_address      = addr;
    bus.i_tlp_requester_id = rid;
    bus.i_tlp_tag          = tag;
  endtask

  // Called at a negedge; leaves the bench at negedge+1 with o_finished seen (or aborted).
  task automatic run_tlp(input bit toggle, input int fc_rise, input int abort_cyc);
    int          cyc = 0;
    bit          stalled = 1'b0;
    bit          pop;
    logic [31:0] held = 32'h0;
    beats.delete();
    last_idx = -1; last_cnt = 0; stb_cnt = 0; trunc_cnt = 0; first_vld = -1; unstable = 0;
    bus.i_enable = 1'b1;
    while (cyc < 400) begin
      bus.i_pcie_fc_ready = (cyc >= fc_rise);
      bus.i_tx_ready      = toggle ? cyc[0] : 1'b1;
      if (cyc == abort_cyc) begin
        rst_n = 1'b0;
        #1;
        return;
      end
      #1;
      if (bus.o_finished) break;
      if (bus.o_truncated) trunc_cnt++;
      if (bus.o_tx_valid && first_vld < 0) first_vld = cyc;
      if (stalled && (!bus.o_tx_valid || bus.o_tx_data !== held)) unstable++;
      stalled = bus.o_tx_valid && !bus.i_tx_ready;
      held    = bus.o_tx_data;
      if (bus.o_tx_valid && bus.i_tx_ready) begin
        if (bus.o_tx_last) begin
          last_idx = beats.size();
          last_cnt++;
        end
        beats.push_back(bus.o_tx_data);
      end
      pop = bus.o_fifo_stb;
      if (pop) stb_cnt++;
      @(posedge clk);
      #1;
      if (pop) begin
        rd++;
        upd_fifo();
      end
      @(negedge clk);
      cyc++;
    end
    chk("tlp_done", {31'b0, bus.o_finished}, 32'h1);
  endtask

  task automatic check_tlp(input string tag, input logic [31:0] h0, input logic [31:0] h1,
                           input logic [31:0] h2, input int n, input int seed);
    logic [31:0] exp;
    chk({tag, "_nbeats"}, 32'(beats.size()), 32'(n));
    for (int i = 0; i < beats.size() && i < n; i++) begin
      exp = (i == 0) ? h0 : (i == 1) ? h1 : (i == 2) ? h2 : dw(seed, i - 3);
      chk($sformatf("%s_beat%0d", tag, i), beats[i], exp);
    end
    chk({tag, "_last_pos"}, 32'(last_idx), 32'(n - 1));
    chk({tag, "_last_cnt"}, 32'(last_cnt), 32'd1);
  endtask

  task automatic finish_tail(input string tag);
    repeat (2) begin
      @(negedge clk);
      chk({tag, "_fin_held"}, {31'b0, bus.o_finished}, 32'h1);
    end
    chk({tag, "_act_low"}, {31'b0, bus.o_fifo_act}, 32'h0);
    bus.i_enable = 1'b0;
    @(negedge clk);
    chk({tag, "_fin_clear"}, {31'b0, bus.o_finished}, 32'h0);
    bus.i_fifo_rdy = 1'b0;
    rd = 0;
    wr = 0;
    upd_fifo();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_enable = 1'b0;
    bus.i_pcie_fc_ready = 1'b0;
    bus.i_fifo_rdy = 1'b0;
    bus.i_tx_ready = 1'b0;
    set_desc(8'h0, 14'h0, 32'h0, 16'h0, 8'h0);
    rd = 0;
    wr = 0;
    upd_fifo();
    #1;
    chk("rst_ctrl", {26'b0, bus.o_fifo_act, bus.o_finished, bus.o_tx_valid,
                     bus.o_tx_last, bus.o_truncated, bus.o_fifo_stb}, 32'h0);
    chk("rst_data", bus.o_tx_data, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: 9-word block, full-rate sink
    set_desc(8'h40, 14'h0, 32'h1000_0006, 16'h0100, 8'h05);
    load(9, 1);
    run_tlp(1'b0, 0, -1);
    check_tlp("t1", 32'h4000_0009, 32'h0100_05FF, 32'h1000_0004, 12, 1);
    chk("t1_latency", 32'(first_vld), 32'd3);
    chk("t1_stb", 32'(stb_cnt), 32'd9);
    chk("t1_trunc", 32'(trunc_cnt), 32'd0);
    finish_tail("t1");

    // T2: single-DW payload uses first-DW byte enables only
    load(1, 2);
    run_tlp(1'b0, 0, -1);
    check_tlp("t2", 32'h4000_0001, 32'h0100_050F, 32'h1000_0004, 4, 2);
    chk("t2_stb", 32'(stb_cnt), 32'd1);
    finish_tail("t2");

    // T3: sink ready toggles every cycle
    load(9, 3);
    run_tlp(1'b1, 0, -1);
    check_tlp("t3", 32'h4000_0009, 32'h0100_05FF, 32'h1000_0004, 12, 3);
    chk("t3_stb", 32'(stb_cnt), 32'd9);
    chk("t3_stable", 32'(unstable), 32'd0);
    finish_tail("t3");

    // T4: no posted credit for 20 cycles after GRAB, different descriptor
    set_desc(8'h60, 14'h0155, 32'hCAFE_0003, 16'hBEEF, 8'h7A);
    load(3, 4);
    run_tlp(1'b0, 21, -1);
    check_tlp("t4", 32'h6005_5403, 32'hBEEF_7AFF, 32'hCAFE_0000, 6, 4);
    chk("t4_first_vld", 32'(first_vld), 32'd22);
    finish_tail("t4");

    // T5: 40-word block capped at 32
    set_desc(8'h40, 14'h0, 32'h1000_0006, 16'h0100, 8'h05);
    load(40, 5);
    run_tlp(1'b0, 0, -1);
    check_tlp("t5", 32'h4000_0020, 32'h0100_05FF, 32'h1000_0004, 35, 5);
    chk("t5_trunc", 32'(trunc_cnt), 32'd1);
    chk("t5_stb", 32'(stb_cnt), 32'd32);
    finish_tail("t5");

    // T6: reset during the fifth data beat, then a clean 2-word TLP
    load(9, 6);
    run_tlp(1'b0, 0, 10);
    chk("t6_beats_before", 32'(beats.size()), 32'd7);
    chk("t6_rst_ctrl", {26'b0, bus.o_fifo_act, bus.o_finished, bus.o_tx_valid,
                        bus.o_tx_last, bus.o_truncated, bus.o_fifo_stb}, 32'h0);
    chk("t6_rst_data", bus.o_tx_data, 32'h0);
    bus.i_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load(2, 7);
    @(negedge clk);
    run_tlp(1'b0, 0, -1);
    check_tlp("t6", 32'h4000_0002, 32'h0100_05FF, 32'h1000_0004, 5, 7);
    chk("t6_stb", 32'(stb_cnt), 32'd2);
    finish_tail("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
